// File: rtl/dla_feeder_pkg.sv
// Shared types and widths for the DLA row feeder: FSM states, count width and
// default beat geometry.
package dla_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } feeder_state_e;

  localparam int unsigned CNT_W      = 12;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned BEAT_W     = DEF_DATA_W * DEF_LANES;

  // Beats in a transfer; 255 bursts of 16 still fit in CNT_W bits.
  function automatic logic [CNT_W-1:0] burst_total(input logic [7:0] num_bursts,
                                                   input int unsigned burst_len);
    return CNT_W'(num_bursts) * CNT_W'(burst_len);
  endfunction

endpackage

// File: rtl/ddr_lane_feeder_if.sv
// External bus bundle of the lane feeder: memory beat handshake, lane outputs
// and control/status.
interface ddr_lane_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4
);
  logic                      start;
  logic [7:0]                num_bursts;
  logic                      mem_valid;
  logic [DATA_W*LANES-1:0]   mem_data;
  logic                      mem_ready;
  logic [DATA_W-1:0]         ddr_0;
  logic [DATA_W-1:0]         ddr_1;
  logic [DATA_W-1:0]         ddr_2;
  logic [DATA_W-1:0]         ddr_3;
  logic                      lane_valid;
  logic                      lane_stall;
  logic                      busy;
  logic                      done;

  modport master (
    output start, num_bursts, mem_valid, mem_data, lane_stall,
    input  mem_ready, ddr_0, ddr_1, ddr_2, ddr_3, lane_valid, busy, done
  );

  modport slave (
    input  start, num_bursts, mem_valid, mem_data, lane_stall,
    output mem_ready, ddr_0, ddr_1, ddr_2, ddr_3, lane_valid, busy, done
  );
endinterface

// File: rtl/dla_fifo_if.sv
// Push/pop port bundle between the feeder controller and its beat FIFO.
interface dla_fifo_if #(
  parameter int unsigned W = 64
);
  logic         push;
  logic         pop;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         full;
  logic         empty;

  modport master (output push, pop, wdata, input rdata, full, empty);
  modport slave  (input push, pop, wdata, output rdata, full, empty);
endinterface

// File: rtl/dla_feeder_fifo.sv
// Show-ahead beat FIFO: rdata always presents the head entry; pointers carry a
// wrap bit so full and empty are distinguishable without a counter.
module dla_feeder_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       i_reset,
  dla_fifo_if.slave  f
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en, rd_en;

  assign f.empty = (wptr_q == rptr_q);
  assign f.full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign f.rdata = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign wr_en = f.push && (!f.full || f.pop);
  assign rd_en = f.pop && !f.empty;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= f.wdata;
  end

endmodule

// File: rtl/ddr_lane_feeder.sv
// Streams memory beats through a small FIFO into a held output register that
// drives the four lane words of one DLA row, framed by a start/done transfer.
module ddr_lane_feeder
  import dla_feeder_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [7:0]              i_num_bursts,
  input  logic                    i_mem_valid,
  input  logic [DATA_W*LANES-1:0] i_mem_data,
  output logic                    o_mem_ready,
  output logic [DATA_W-1:0]       o_ddr_0,
  output logic [DATA_W-1:0]       o_ddr_1,
  output logic [DATA_W-1:0]       o_ddr_2,
  output logic [DATA_W-1:0]       o_ddr_3,
  output logic                    o_lane_valid,
  input  logic                    i_lane_stall,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int unsigned BW = DATA_W * LANES;

  feeder_state_e    state_q;
  logic [CNT_W-1:0] total_q, acc_cnt_q, pop_cnt_q;
  logic [CNT_W-1:0] total_d, acc_cnt_d, pop_cnt_d;
  logic [BW-1:0]    out_q;
  logic             lane_valid_q;
  logic             push, pop, consumed;

  dla_fifo_if #(.W(BW)) fifo_bus ();

  dla_feeder_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .f       (fifo_bus)
  );

  assign total_d   = burst_total(i_num_bursts, BURST_LEN);
  assign acc_cnt_d = acc_cnt_q + CNT_W'(1);
  assign pop_cnt_d = pop_cnt_q + CNT_W'(1);

  assign o_mem_ready = (state_q == STREAM) && !fifo_bus.full && (acc_cnt_q < total_q);
  assign push        = i_mem_valid && o_mem_ready;
  // The output register is free when empty or when its word leaves this cycle.
  assign consumed    = !lane_valid_q || !i_lane_stall;
  assign pop         = (state_q == STREAM) && !fifo_bus.empty && consumed;

  assign fifo_bus.push  = push;
  assign fifo_bus.pop   = pop;
  assign fifo_bus.wdata = i_mem_data;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      total_q      <= '0;
      acc_cnt_q    <= '0;
      pop_cnt_q    <= '0;
      out_q        <= '0;
      lane_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            total_q   <= total_d;
            acc_cnt_q <= '0;
            pop_cnt_q <= '0;
            state_q   <= (total_d == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (push) acc_cnt_q <= acc_cnt_d;
          if (pop_cnt_q == total_q && consumed) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (pop) begin
        out_q        <= fifo_bus.rdata;
        lane_valid_q <= 1'b1;
        pop_cnt_q    <= pop_cnt_d;
      end else if (lane_valid_q && !i_lane_stall) begin
        lane_valid_q <= 1'b0;
      end
    end
  end

  assign o_ddr_0      = out_q[0*DATA_W +: DATA_W];
  assign o_ddr_1      = out_q[1*DATA_W +: DATA_W];
  assign o_ddr_2      = out_q[2*DATA_W +: DATA_W];
  assign o_ddr_3      = out_q[3*DATA_W +: DATA_W];
  assign o_lane_valid = lane_valid_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_ddr_lane_feeder.sv
// Directed bench for ddr_lane_feeder: a cycle table for start/latency/stall
// behaviour, then whole transfers checked word by word against beat(k).
module tb_ddr_lane_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_lane_feeder_if #(.DATA_W(16), .LANES(4)) bus ();

  ddr_lane_feeder #(
    .DATA_W     (16),
    .LANES      (4),
    .BURST_LEN  (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .i_reset      (rst),
    .i_start      (bus.start),
    .i_num_bursts (bus.num_bursts),
    .i_mem_valid  (bus.mem_valid),
    .i_mem_data   (bus.mem_data),
    .o_mem_ready  (bus.mem_ready),
    .o_ddr_0      (bus.ddr_0),
    .o_ddr_1      (bus.ddr_1),
    .o_ddr_2      (bus.ddr_2),
    .o_ddr_3      (bus.ddr_3),
    .o_lane_valid (bus.lane_valid),
    .i_lane_stall (bus.lane_stall),
    .o_busy       (bus.busy),
    .o_done       (bus.done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int k);
    logic [15:0] b;
    b = 16'(4 * k);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // {ready, lane_valid, busy, done, ddr_0, ddr_3}
  function automatic logic [35:0] snap();
    return {bus.mem_ready, bus.lane_valid, bus.busy, bus.done, bus.ddr_0, bus.ddr_3};
  endfunction

  function automatic logic [63:0] lanes();
    return {bus.ddr_3, bus.ddr_2, bus.ddr_1, bus.ddr_0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        start;
    logic [7:0]  nb;
    logic        mv;
    logic [63:0] data;
    logic        stall;
    logic [35:0] exp;
  } vec_t;

  function automatic vec_t mk(input string name, input logic start, input logic [7:0] nb,
                              input logic mv, input logic [63:0] data, input logic stall,
                              input logic [35:0] exp);
    vec_t v;
    v.name = name; v.start = start; v.nb = nb; v.mv = mv;
    v.data = data; v.stall = stall; v.exp = exp;
    return v;
  endfunction

  // One transfer; reset_after > 0 aborts with reset once that many beats are in.
  task automatic run_xfer(input string tag, input int nb, input int stall_cyc,
                          input bit restart_busy, input int reset_after);
    int acc = 0, words = 0, dones = 0;
    int first_c = -1, last_c = -1, done_c = -1;
    bit fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      bus.start      = (c == 0) || (restart_busy && c == 5);
      bus.num_bursts = (c == 0) ? 8'(nb) : 8'd7;
      bus.mem_valid  = (c > 0);
      bus.mem_data   = beat(acc);
      bus.lane_stall = (c < stall_cyc);
      if (reset_after > 0 && acc == reset_after) begin
        rst = 1'b1;
        #1;
        check({tag, " ctl at reset"}, 64'(snap()), 64'd0);
        check({tag, " lanes at reset"}, lanes(), 64'd0);
        bus.start = 1'b0;
        bus.mem_valid = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          cyc();
          check($sformatf("%s busy/done after abort %0d", tag, i),
                {62'd0, bus.busy, bus.done}, 64'd0);
        end
        return;
      end
      #1;
      if (bus.lane_valid && !bus.lane_stall) begin
        check($sformatf("%s word%0d", tag, words), lanes(), beat(words));
        if (first_c < 0) first_c = c;
        last_c = c;
        words++;
      end
      if (bus.done) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (stall_cyc > 0 && c == stall_cyc - 1) begin
        check({tag, " accepts when full"}, 64'(acc), 64'd9);
        check({tag, " ready while full"}, {63'd0, bus.mem_ready}, 64'd0);
      end
      if (bus.mem_ready && bus.mem_valid) acc++;
      if (done_c >= 0 && c >= done_c + 2) fin = 1'b1;
      cyc();
    end
    bus.start = 1'b0;
    bus.mem_valid = 1'b0;
    bus.lane_stall = 1'b0;
    check({tag, " finished in budget"}, {63'd0, fin}, 64'd1);
    check({tag, " words"}, 64'(words), 64'(nb * 16));
    check({tag, " accepts"}, 64'(acc), 64'(nb * 16));
    check({tag, " done pulses"}, 64'(dones), 64'd1);
    check({tag, " done after last word"}, 64'(done_c), 64'(last_c + 1));
    check({tag, " idle at end"}, {63'd0, bus.busy}, 64'd0);
    if (stall_cyc == 0) begin
      check({tag, " first word latency"}, 64'(first_c), 64'd3);
      check({tag, " consecutive words"}, 64'(last_c - first_c + 1), 64'(nb * 16));
    end
  endtask

  localparam logic [63:0] D = 64'hDDDD_CCCC_BBBB_AAAA;
  vec_t tbl[11];

  initial begin
    tbl[0]  = mk("idle",          0, 8'd0, 0, '0, 0, {4'b0000, 16'h0, 16'h0});
    tbl[1]  = mk("start zero",    1, 8'd0, 0, '0, 0, {4'b0000, 16'h0, 16'h0});
    tbl[2]  = mk("zero done",     0, 8'd0, 0, '0, 0, {4'b0011, 16'h0, 16'h0});
    tbl[3]  = mk("back idle",     0, 8'd0, 0, '0, 0, {4'b0000, 16'h0, 16'h0});
    tbl[4]  = mk("start one",     1, 8'd1, 1, D,  0, {4'b0000, 16'h0, 16'h0});
    tbl[5]  = mk("accept beat",   0, 8'd0, 1, D,  0, {4'b1010, 16'h0, 16'h0});
    tbl[6]  = mk("in fifo",       0, 8'd0, 0, '0, 0, {4'b1010, 16'h0, 16'h0});
    tbl[7]  = mk("valid +2",      0, 8'd0, 0, '0, 1, {4'b1110, 16'hAAAA, 16'hDDDD});
    tbl[8]  = mk("stall hold",    0, 8'd0, 0, '0, 1, {4'b1110, 16'hAAAA, 16'hDDDD});
    tbl[9]  = mk("consume",       0, 8'd0, 0, '0, 0, {4'b1110, 16'hAAAA, 16'hDDDD});
    tbl[10] = mk("valid clear",   0, 8'd0, 0, '0, 0, {4'b1010, 16'hAAAA, 16'hDDDD});

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_bursts = 8'd0;
    bus.mem_valid = 1'b0;
    bus.mem_data = '0;
    bus.lane_stall = 1'b0;
    repeat (2) cyc();
    check("reset state", 64'(snap()), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus.start      = tbl[i].start;
      bus.num_bursts = tbl[i].nb;
      bus.mem_valid  = tbl[i].mv;
      bus.mem_data   = tbl[i].data;
      bus.lane_stall = tbl[i].stall;
      #1;
      check({"tbl ", tbl[i].name}, 64'(snap()), 64'(tbl[i].exp));
      cyc();
    end

    bus.start = 1'b0;
    bus.mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort table transfer", {28'd0, snap()}, 64'd0);
    cyc();
    rst = 1'b0;

    run_xfer("one burst", 1, 0, 1'b0, 0);
    run_xfer("stall fill", 2, 20, 1'b0, 0);
    run_xfer("mid reset", 1, 0, 1'b0, 5);
    run_xfer("after reset", 1, 0, 1'b0, 0);
    run_xfer("extra beats", 1, 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
